// File: rtl/POLI_types_pkg.sv
// Shared POLI bus types: word size, CRC peripheral register addresses, status/control
// bit positions and the CRC engine state encoding.
package POLI_types_pkg;

    localparam int unsigned WORD_SIZE = 32;

    localparam logic [WORD_SIZE-1:0] CRC_CONFIG_ADDR  = 32'h0000_0000;
    localparam logic [WORD_SIZE-1:0] CRC_INPUT_ADDR   = 32'h0000_0004;
    localparam logic [WORD_SIZE-1:0] CRC_CONTROL_ADDR = 32'h0000_0008;
    localparam logic [WORD_SIZE-1:0] CRC_STATUS_ADDR  = 32'h0000_000C;
    localparam logic [WORD_SIZE-1:0] CRC_OUTPUT_ADDR  = 32'h0000_0010;

    localparam int unsigned CRC_STATUS_DONE_BIT = 0;
    localparam int unsigned CRC_STATUS_BUSY_BIT = 1;
    localparam int unsigned CRC_CTRL_START_BIT  = 0;

    typedef enum logic [0:0] {
        CRC_IDLE  = 1'b0,
        CRC_SHIFT = 1'b1
    } crc_state_t;

endpackage

// File: rtl/crc32_serial_engine.sv
// Bit-serial, MSB-first 32-bit CRC: one data bit per cycle, no reflection, no final XOR.
module crc32_serial_engine
    import POLI_types_pkg::*;
(
    input  logic        CLK,
    input  logic        nRST,
    input  logic        start,
    input  logic [31:0] poly,
    input  logic [31:0] data,
    input  logic [31:0] seed,
    output logic [31:0] crc,
    output logic        busy,
    output logic        done
);

    crc_state_t  state_q, state_d;
    logic [31:0] crc_q, crc_d;
    logic [4:0]  bitcnt_q, bitcnt_d;
    logic        done_q, done_d;
    logic        fb;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= CRC_IDLE;
            crc_q    <= '0;
            bitcnt_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            crc_q    <= crc_d;
            bitcnt_q <= bitcnt_d;
            done_q   <= done_d;
        end
    end

    // A start seen while shifting is ignored, so the bit counter is never restarted mid-run.
    always_comb begin
        state_d  = state_q;
        crc_d    = crc_q;
        bitcnt_d = bitcnt_q;
        done_d   = done_q;
        fb       = 1'b0;
        case (state_q)
            CRC_IDLE: begin
                if (start) begin
                    state_d  = CRC_SHIFT;
                    crc_d    = seed;
                    bitcnt_d = 5'd31;
                    done_d   = 1'b0;
                end
            end
            CRC_SHIFT: begin
                fb       = crc_q[31] ^ data[bitcnt_q];
                crc_d    = {crc_q[30:0], 1'b0} ^ (fb ? poly : 32'h0);
                bitcnt_d = bitcnt_q - 5'd1;
                if (bitcnt_q == 5'd0) begin
                    state_d = CRC_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = CRC_IDLE;
        endcase
    end

    assign crc  = crc_q;
    assign busy = (state_q == CRC_SHIFT);
    assign done = done_q;

endmodule

// File: rtl/apb_crc_responder.sv
// APB-style completer for the POLI CRC peripheral: registered PREADY handshake with
// programmable wait states, register file and address decode around the serial CRC engine.
module apb_crc_responder
    import POLI_types_pkg::*;
#(
    parameter logic [31:0] SEED        = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 1
)
(
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic                 PSEL,
    input  logic                 PENABLE,
    input  logic                 PWRITE,
    input  logic [WORD_SIZE-1:0] PADDR,
    input  logic [WORD_SIZE-1:0] PWDATA,
    output logic [WORD_SIZE-1:0] PRDATA,
    output logic                 PREADY
);

    logic [31:0]          poly_q;
    logic [31:0]          data_q;
    logic [3:0]           wait_cnt;
    logic                 pready_q;
    logic [WORD_SIZE-1:0] prdata_q;
    logic [WORD_SIZE-1:0] rd_value;
    logic [31:0]          crc;
    logic                 busy;
    logic                 done;
    logic                 write_commit;
    logic                 start;
    logic                 unused_penable;

    // The initiator may loop PREADY back onto PENABLE, so PENABLE plays no part in the handshake.
    assign unused_penable = PENABLE;

    assign write_commit = PSEL && pready_q && PWRITE && !busy;
    assign start        = write_commit && (PADDR == CRC_CONTROL_ADDR) && PWDATA[CRC_CTRL_START_BIT];

    always_comb begin
        rd_value = '0;
        case (PADDR)
            CRC_CONFIG_ADDR:  rd_value = poly_q;
            CRC_INPUT_ADDR:   rd_value = data_q;
            CRC_CONTROL_ADDR: rd_value[CRC_CTRL_START_BIT] = busy;
            CRC_STATUS_ADDR: begin
                rd_value[CRC_STATUS_BUSY_BIT] = busy;
                rd_value[CRC_STATUS_DONE_BIT] = done;
            end
            CRC_OUTPUT_ADDR:  rd_value = crc;
            default:          rd_value = '0;
        endcase
    end

    // Read data is captured on the same edge that raises PREADY and cleared with it.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pready_q <= 1'b0;
            prdata_q <= '0;
            wait_cnt <= '0;
        end else if (pready_q) begin
            pready_q <= 1'b0;
            prdata_q <= '0;
            wait_cnt <= '0;
        end else if (PSEL) begin
            if (wait_cnt == 4'(WAIT_STATES - 1)) begin
                pready_q <= 1'b1;
                prdata_q <= rd_value;
                wait_cnt <= '0;
            end else begin
                wait_cnt <= wait_cnt + 4'd1;
            end
        end else begin
            wait_cnt <= '0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            poly_q <= '0;
            data_q <= '0;
        end else if (write_commit) begin
            if (PADDR == CRC_CONFIG_ADDR) poly_q <= PWDATA;
            if (PADDR == CRC_INPUT_ADDR)  data_q <= PWDATA;
        end
    end

    crc32_serial_engine u_engine (
        .CLK   (CLK),
        .nRST  (nRST),
        .start (start),
        .poly  (poly_q),
        .data  (data_q),
        .seed  (SEED),
        .crc   (crc),
        .busy  (busy),
        .done  (done)
    );

    assign PREADY = pready_q;
    assign PRDATA = prdata_q;

endmodule

// File: tb/tb_apb_crc_responder.sv
// Directed bench for apb_crc_responder: handshake timing, register access, CRC results,
// busy protection, abort/unmapped accesses and async reset, against hand-computed values.
module tb_apb_crc_responder;
    import POLI_types_pkg::*;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;

    int          checkCount = 0;
    int          passCount  = 0;
    int unsigned edgeCount  = 0;

    apb_crc_responder dut (
        .CLK     (CLK),
        .nRST    (nRST),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) edgeCount <= edgeCount + 1;

    // The initiator ties PENABLE to PREADY, as the board FSM does.
    assign PENABLE = PREADY;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    endtask

    // One bus access; returns read data, cycles until PREADY and PREADY one cycle after completion.
    task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                                 output logic [31:0] rdata, output int waitCycles, output logic readyAfter);
        @(negedge CLK);
        PSEL = 1'b1; PWRITE = wr; PADDR = addr; PWDATA = wdata;
        waitCycles = 0; rdata = '0; readyAfter = 1'b0;
        do begin
            @(posedge CLK); #1;
            waitCycles++;
        end while (!PREADY && waitCycles < 40);
        if (!PREADY) begin
            checkOutput($sformatf("PREADY timeout addr 0x%0h", addr), {31'b0, PREADY}, 32'd1);
            PSEL = 1'b0;
        end else begin
            rdata = PRDATA;
            @(posedge CLK); #1;
            readyAfter = PREADY;
            PSEL = 1'b0; PWRITE = 1'b0;
        end
    endtask

    task automatic writeReg(input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] rd; int wc; logic ra;
        applyStimulus(1'b1, addr, wdata, rd, wc, ra);
    endtask

    task automatic readReg(input logic [31:0] addr, output logic [31:0] rdata);
        int wc; logic ra;
        applyStimulus(1'b0, addr, 32'h0, rdata, wc, ra);
    endtask

    task automatic waitUntilEdge(input int unsigned n);
        while (edgeCount < n) begin
            @(posedge CLK); #1;
        end
    endtask

    typedef struct {
        logic [31:0] poly;
        logic [31:0] data;
        logic [31:0] crc;
    } vec_t;

    vec_t vecs[5] = '{
        '{32'hDEADBEEF, 32'h0000_0001, 32'hDEADBEEF},
        '{32'h04C11DB7, 32'h0000_0002, 32'h09823B6E},
        '{32'h04C11DB7, 32'h0000_0003, 32'h0D4326D9},
        '{32'hDEADBEEF, 32'h0000_0002, 32'h63F6C331},
        '{32'hDEADBEEF, 32'h0000_0000, 32'h0000_0000}
    };

    initial begin
        logic [31:0] rd;
        int          wc;
        logic        ra;
        int unsigned startEdge;
        int          polls;

        nRST = 1'b0; PSEL = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
        #1;
        checkOutput("reset PREADY", {31'b0, PREADY}, 32'd0);
        checkOutput("reset PRDATA", PRDATA, 32'd0);
        repeat (2) @(negedge CLK);
        nRST = 1'b1;

        // Handshake timing on a CONFIG write, then readback.
        applyStimulus(1'b1, CRC_CONFIG_ADDR, 32'hDEADBEEF, rd, wc, ra);
        checkOutput("write latency cycles", wc, 32'd1);
        checkOutput("PREADY one cycle wide", {31'b0, ra}, 32'd0);
        checkOutput("PRDATA zero after PREADY", PRDATA, 32'd0);
        applyStimulus(1'b0, CRC_CONFIG_ADDR, 32'h0, rd, wc, ra);
        checkOutput("CONFIG readback", rd, 32'hDEADBEEF);
        checkOutput("read latency cycles", wc, 32'd1);

        // CRC with data=1: busy through the 32nd shift, done afterwards.
        writeReg(CRC_INPUT_ADDR, 32'h0000_0001);
        writeReg(CRC_CONTROL_ADDR, 32'h1);
        startEdge = edgeCount;
        readReg(CRC_CONTROL_ADDR, rd);
        checkOutput("CONTROL busy read", rd, 32'h1);
        waitUntilEdge(startEdge + 31);
        readReg(CRC_STATUS_ADDR, rd);
        checkOutput("STATUS busy at 32nd shift", rd, 32'h2);
        readReg(CRC_STATUS_ADDR, rd);
        checkOutput("STATUS done", rd, 32'h1);
        readReg(CRC_OUTPUT_ADDR, rd);
        checkOutput("OUTPUT data=1", rd, 32'hDEADBEEF);

        // CRC with data=0: done visible exactly one edge after the last shift.
        writeReg(CRC_INPUT_ADDR, 32'h0);
        writeReg(CRC_CONTROL_ADDR, 32'h1);
        startEdge = edgeCount;
        readReg(CRC_STATUS_ADDR, rd);
        checkOutput("STATUS done cleared on start", rd, 32'h2);
        waitUntilEdge(startEdge + 32);
        readReg(CRC_STATUS_ADDR, rd);
        checkOutput("STATUS done after 32 shifts", rd, 32'h1);
        readReg(CRC_OUTPUT_ADDR, rd);
        checkOutput("OUTPUT data=0", rd, 32'h0);

        // Busy protection: INPUT write and a second start during the run are ignored.
        writeReg(CRC_INPUT_ADDR, 32'h0000_0001);
        writeReg(CRC_CONTROL_ADDR, 32'h1);
        startEdge = edgeCount;
        applyStimulus(1'b1, CRC_INPUT_ADDR, 32'hFFFF_FFFF, rd, wc, ra);
        checkOutput("busy write still completes", wc, 32'd1);
        writeReg(CRC_CONTROL_ADDR, 32'h1);
        waitUntilEdge(startEdge + 32);
        readReg(CRC_STATUS_ADDR, rd);
        checkOutput("no restart while busy", rd, 32'h1);
        readReg(CRC_INPUT_ADDR, rd);
        checkOutput("INPUT unchanged while busy", rd, 32'h0000_0001);
        readReg(CRC_OUTPUT_ADDR, rd);
        checkOutput("OUTPUT busy-protected", rd, 32'hDEADBEEF);

        // Aborted access and unmapped address.
        @(negedge CLK);
        PSEL = 1'b1; PWRITE = 1'b1; PADDR = CRC_CONFIG_ADDR; PWDATA = 32'h1234_5678;
        #2 PSEL = 1'b0; PWRITE = 1'b0;
        @(posedge CLK); #1;
        checkOutput("abort no PREADY", {31'b0, PREADY}, 32'd0);
        readReg(CRC_CONFIG_ADDR, rd);
        checkOutput("abort no write", rd, 32'hDEADBEEF);
        applyStimulus(1'b1, 32'h0000_0FFC, 32'hA5A5_A5A5, rd, wc, ra);
        checkOutput("unmapped write PREADY", wc, 32'd1);
        readReg(32'h0000_0FFC, rd);
        checkOutput("unmapped read", rd, 32'h0);
        writeReg(CRC_OUTPUT_ADDR, 32'h5555_5555);
        readReg(CRC_OUTPUT_ADDR, rd);
        checkOutput("OUTPUT write ignored", rd, 32'hDEADBEEF);

        // Board-style sequence over several vectors.
        foreach (vecs[i]) begin
            writeReg(CRC_CONFIG_ADDR, vecs[i].poly);
            writeReg(CRC_INPUT_ADDR, vecs[i].data);
            writeReg(CRC_CONTROL_ADDR, 32'h1);
            readReg(CRC_STATUS_ADDR, rd);
            checkOutput($sformatf("vec%0d STATUS after start", i), rd, 32'h2);
            polls = 0;
            do begin
                readReg(CRC_STATUS_ADDR, rd);
                polls++;
            end while (rd[CRC_STATUS_DONE_BIT] !== 1'b1 && polls < 40);
            checkOutput($sformatf("vec%0d STATUS final", i), rd, 32'h1);
            readReg(CRC_OUTPUT_ADDR, rd);
            checkOutput($sformatf("vec%0d OUTPUT", i), rd, vecs[i].crc);
        end

        // Asynchronous reset while PREADY is high and the engine is running.
        writeReg(CRC_CONFIG_ADDR, 32'hDEADBEEF);
        writeReg(CRC_INPUT_ADDR, 32'h0000_0001);
        writeReg(CRC_CONTROL_ADDR, 32'h1);
        @(negedge CLK);
        PSEL = 1'b1; PWRITE = 1'b0; PADDR = CRC_STATUS_ADDR;
        @(posedge CLK); #1;
        checkOutput("pre-reset PRDATA", PRDATA, 32'h2);
        nRST = 1'b0;
        #1;
        checkOutput("mid-transfer reset PREADY", {31'b0, PREADY}, 32'd0);
        checkOutput("mid-transfer reset PRDATA", PRDATA, 32'd0);
        PSEL = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;
        readReg(CRC_STATUS_ADDR, rd);
        checkOutput("STATUS after reset", rd, 32'h0);
        readReg(CRC_OUTPUT_ADDR, rd);
        checkOutput("OUTPUT after reset", rd, 32'h0);
        readReg(CRC_CONFIG_ADDR, rd);
        checkOutput("CONFIG after reset", rd, 32'h0);
        readReg(CRC_INPUT_ADDR, rd);
        checkOutput("INPUT after reset", rd, 32'h0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, passed %0d of %0d", passCount, checkCount);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
